// File: rtl/dlsc_pcie_s6_outbound_read_alloc.sv
// dlsc_pcie_s6_outbound_read_alloc: reserves a PCIe tag and read-buffer dwords per AXI read command, then issues the read request descriptor
// Ports: axi_ar_* command in; buf_ar_* length push to the read buffer; alloc_* tag-memory write and init;
// dealloc_* freed tag/dword pulses; tlp_* request descriptor out; rd_busy/rd_disable control.
// `define DLSC_PCIE_S6_RD_ALLOC_PIPE_EN registers the resource comparisons (one extra ST_ALLOC cycle).
module dlsc_pcie_s6_outbound_read_alloc #(
  parameter int ADDR = 32,
  parameter int LEN  = 4,
  parameter int TAG  = 5,
  parameter int BUFA = 9
) (
  input  logic            clk,
  input  logic            rst,
  output logic            axi_ar_ready,
  input  logic            axi_ar_valid,
  input  logic [ADDR-1:0] axi_ar_addr,
  input  logic [LEN-1:0]  axi_ar_len,
  input  logic            buf_ar_ready,
  output logic            buf_ar_valid,
  output logic [LEN-1:0]  buf_ar_len,
  output logic            alloc_init,
  output logic            alloc_valid,
  output logic [TAG:0]    alloc_tag,
  output logic [BUFA:0]   alloc_bufa,
  input  logic            dealloc_tag,
  input  logic            dealloc_data,
  input  logic            tlp_ready,
  output logic            tlp_valid,
  output logic [ADDR-3:0] tlp_addr,
  output logic [LEN:0]    tlp_len,
  output logic [TAG-1:0]  tlp_tag,
  output logic            rd_busy,
  input  logic            rd_disable
);
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ALLOC, ST_REQ} state_t;
  localparam logic [TAG:0]  TAGS   = {1'b1, {TAG{1'b0}}};
  localparam logic [BUFA:0] DWORDS = {1'b1, {BUFA{1'b0}}};
  state_t state, state_n;
  logic [TAG:0] tags_free;
  logic [BUFA:0] data_free, need;
  logic res_ok, ok, addr_unused;
  assign addr_unused = ^axi_ar_addr[1:0];
  // buf_ar_len doubles as the latched burst length of the command in flight
  assign need = {{(BUFA+1-LEN){1'b0}}, buf_ar_len} + {{BUFA{1'b0}}, 1'b1};
`ifdef DLSC_PCIE_S6_RD_ALLOC_PIPE_EN
  // Stale-by-one comparison is safe: only an allocation lowers the counters, and it leaves ST_ALLOC
  logic res_ok_r, alloc_wait;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      res_ok_r   <= 1'b0;
      alloc_wait <= 1'b0;
    end else begin
      res_ok_r   <= (tags_free != '0) && (data_free >= need);
      alloc_wait <= state == ST_ALLOC;
    end
  assign res_ok = res_ok_r && alloc_wait;
`else
  assign res_ok = (tags_free != '0) && (data_free >= need);
`endif
  assign ok = res_ok && buf_ar_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_INIT;
    else     state <= state_n;
  always_comb begin
    state_n = (state == ST_INIT) ? ST_IDLE :
              (state == ST_IDLE  && axi_ar_valid && !rd_disable) ? ST_ALLOC :
              (state == ST_ALLOC && ok) ? ST_REQ :
              (state == ST_REQ   && tlp_ready) ? ST_IDLE : state;
  end
  always_comb begin
    alloc_init   = state == ST_INIT;
    axi_ar_ready = (state == ST_IDLE) && !rd_disable;
    alloc_valid  = (state == ST_ALLOC) && ok;
    buf_ar_valid = (state == ST_ALLOC) && ok;
    tlp_valid    = state == ST_REQ;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tlp_addr   <= '0;
      tlp_len    <= '0;
      tlp_tag    <= '0;
      buf_ar_len <= '0;
      alloc_tag  <= '0;
      alloc_bufa <= '0;
      tags_free  <= TAGS;
      data_free  <= DWORDS;
      rd_busy    <= 1'b0;
    end else begin
      if (axi_ar_valid && axi_ar_ready) begin
        tlp_addr   <= axi_ar_addr[ADDR-1:2];
        tlp_len    <= {1'b0, axi_ar_len} + {{LEN{1'b0}}, 1'b1};
        buf_ar_len <= axi_ar_len;
      end
      if (alloc_valid) begin
        tlp_tag    <= alloc_tag[TAG-1:0];
        alloc_tag  <= alloc_tag + {{TAG{1'b0}}, 1'b1};
        alloc_bufa <= alloc_bufa + need;
      end
      tags_free <= tags_free + {{TAG{1'b0}}, dealloc_tag} - {{TAG{1'b0}}, alloc_valid};
      data_free <= data_free + {{BUFA{1'b0}}, dealloc_data} - (alloc_valid ? need : '0);
      rd_busy   <= (state != ST_IDLE) || (tags_free != TAGS) || (data_free != DWORDS);
    end
endmodule

// File: tb/tb_dlsc_pcie_s6_outbound_read_alloc.sv
// tb_dlsc_pcie_s6_outbound_read_alloc: self-checking bench with a transaction-level resource model
module tb_dlsc_pcie_s6_outbound_read_alloc;
  logic clk = 0, rst = 1;
  logic axi_ar_ready, axi_ar_valid = 0;
  logic [31:0] axi_ar_addr = 0;
  logic [3:0] axi_ar_len = 0;
  logic buf_ar_ready = 1, buf_ar_valid;
  logic [3:0] buf_ar_len;
  logic alloc_init, alloc_valid;
  logic [5:0] alloc_tag;
  logic [9:0] alloc_bufa;
  logic dealloc_tag = 0, dealloc_data = 0, tlp_ready = 1, tlp_valid;
  logic [29:0] tlp_addr;
  logic [4:0] tlp_len, tlp_tag;
  logic rd_busy, rd_disable = 0;
  int n_cmp = 0, n_bad = 0;
  int m_tags, m_data, m_tag_ptr, m_bufa, m_tlp_tag;
  bit m_busy;
  int cap_tag, cap_bufa, cap_stall, cap_addr, cap_len, cap_ttag;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  len;
    logic [29:0] t_addr;
    logic [4:0]  t_len;
    logic [5:0]  tag;
    logic [9:0]  bufa;
  } vec_t;
  vec_t tv[4];

  always #5 clk = ~clk;

  dlsc_pcie_s6_outbound_read_alloc dut (
    .clk(clk), .rst(rst),
    .axi_ar_ready(axi_ar_ready), .axi_ar_valid(axi_ar_valid), .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len),
    .buf_ar_ready(buf_ar_ready), .buf_ar_valid(buf_ar_valid), .buf_ar_len(buf_ar_len),
    .alloc_init(alloc_init), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_bufa(alloc_bufa),
    .dealloc_tag(dealloc_tag), .dealloc_data(dealloc_data),
    .tlp_ready(tlp_ready), .tlp_valid(tlp_valid), .tlp_addr(tlp_addr), .tlp_len(tlp_len), .tlp_tag(tlp_tag),
    .rd_busy(rd_busy), .rd_disable(rd_disable)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bump_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no handshake within cycle budget at %0t", name, $time);
  endtask

  task automatic chk_common();
    chk("alloc_tag", alloc_tag, m_tag_ptr);
    chk("alloc_bufa", alloc_bufa, m_bufa);
    chk("rd_busy", rd_busy, m_busy);
    chk("alloc_init", alloc_init, 0);
  endtask

  // modes: 0 quiet, 1 random, 2 free a tag+dword on 4th ALLOC cycle, 3 backpressure, 4 free on 1st ALLOC cycle, 5 drain
  task automatic drive(input int mode, input int ph, input int n);
    dealloc_tag = 0; dealloc_data = 0; buf_ar_ready = 1; tlp_ready = 1; rd_disable = 0;
    case (mode)
      1: begin
        buf_ar_ready = $urandom_range(3, 0) != 0;
        tlp_ready    = $urandom_range(1, 0) != 0;
        dealloc_tag  = (m_tags < 32) && ($urandom_range(2, 0) == 0);
        dealloc_data = (m_data < 512) && ($urandom_range(1, 0) == 0);
        if (ph != 0) rd_disable = $urandom_range(1, 0) != 0;
      end
      2: if (ph == 1 && n == 3) begin dealloc_tag = m_tags < 32; dealloc_data = m_data < 512; end
      3: begin
        if (ph == 1) buf_ar_ready = n >= 4;
        if (ph == 2) tlp_ready = n >= 10;
      end
      4: if (ph == 1 && n == 0) begin dealloc_tag = m_tags < 32; dealloc_data = m_data < 512; end
      5: begin dealloc_tag = m_tags < 32; dealloc_data = m_data < 512; end
      default: ;
    endcase
  endtask

  task automatic account(input int ph, input bit av, input int l);
    m_busy = (ph != 0) || (m_tags != 32) || (m_data != 512);
    if (av) begin
      m_tags--;
      m_data -= l + 1;
      m_tag_ptr = (m_tag_ptr + 1) % 64;
      m_bufa = (m_bufa + l + 1) % 1024;
    end
    if (dealloc_tag) m_tags++;
    if (dealloc_data) m_data++;
    assert (m_tags <= 32 && m_data <= 512) else $fatal(1, "FAIL invariant: tags=%0d data=%0d", m_tags, m_data);
  endtask

  task automatic do_reset();
    rst = 1; axi_ar_valid = 0; drive(0, 0, 0);
    m_tags = 32; m_data = 512; m_tag_ptr = 0; m_bufa = 0; m_tlp_tag = 0; m_busy = 0;
    @(posedge clk); #1;
    chk("rst_ready", axi_ar_ready, 0); chk("rst_alloc_valid", alloc_valid, 0);
    chk("rst_buf_valid", buf_ar_valid, 0); chk("rst_tlp_valid", tlp_valid, 0);
    chk("rst_init", alloc_init, 1); chk("rst_busy", rd_busy, 0);
    chk("rst_tag", alloc_tag, 0); chk("rst_bufa", alloc_bufa, 0);
    chk("rst_tlp_addr", tlp_addr, 0); chk("rst_tlp_len", tlp_len, 0); chk("rst_tlp_tag", tlp_tag, 0);
    rst = 0; #1;
    chk("init_flag", alloc_init, 1); chk("init_ready", axi_ar_ready, 0); chk("init_busy", rd_busy, 0);
    m_busy = 1;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cnt, input int mode, input bit dis);
    for (int i = 0; i < cnt; i++) begin
      drive(mode, 0, i); axi_ar_valid = dis; rd_disable = dis; #1;
      chk("idle_ready", axi_ar_ready, !dis);
      chk("idle_alloc_valid", alloc_valid, 0);
      chk("idle_tlp_valid", tlp_valid, 0);
      chk_common();
      account(0, 0, 0); @(posedge clk); #1;
    end
    axi_ar_valid = 0; rd_disable = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((m_tags < 32 || m_data < 512) && n < 2000) begin
      idle(1, 5, 0);
      n++;
    end
    idle(2, 0, 0);
  endtask

  task automatic do_cmd(input logic [31:0] a, input logic [3:0] l, input int mode);
    int n;
    bit av, hs;
    drive(mode, 0, 0); axi_ar_valid = 1; axi_ar_addr = a; axi_ar_len = l; #1;
    chk("ar_ready", axi_ar_ready, 1); chk("idle_alloc_valid", alloc_valid, 0); chk("idle_tlp_valid", tlp_valid, 0);
    chk_common();
    account(0, 0, 0); @(posedge clk); #1;
    axi_ar_valid = 0; axi_ar_addr = $urandom; axi_ar_len = 4'($urandom);
    n = 0;
    forever begin
      drive(mode, 1, n); #1;
      av = (m_tags > 0) && (m_data >= l + 1) && buf_ar_ready;
      chk("alloc_valid", alloc_valid, av); chk("buf_ar_valid", buf_ar_valid, av);
      chk("alloc_ar_ready", axi_ar_ready, 0); chk("alloc_tlp_valid", tlp_valid, 0);
      chk_common();
      if (av) begin
        chk("buf_ar_len", buf_ar_len, l);
        cap_tag = alloc_tag; cap_bufa = alloc_bufa; cap_stall = n;
        m_tlp_tag = m_tag_ptr % 32;
      end
      account(1, av, l); @(posedge clk); #1;
      if (av) break;
      if (++n > 300) begin bump_timeout("alloc_timeout"); return; end
    end
    n = 0;
    forever begin
      drive(mode, 2, n); #1;
      chk("tlp_valid", tlp_valid, 1); chk("tlp_addr", tlp_addr, a[31:2]);
      chk("tlp_len", tlp_len, l + 1); chk("tlp_tag", tlp_tag, m_tlp_tag);
      chk("req_ar_ready", axi_ar_ready, 0); chk("req_alloc_valid", alloc_valid, 0);
      chk_common();
      cap_addr = tlp_addr; cap_len = tlp_len; cap_ttag = tlp_tag;
      hs = tlp_ready;
      account(2, 0, 0); @(posedge clk); #1;
      if (hs) break;
      if (++n > 300) begin bump_timeout("req_timeout"); return; end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tv[0] = '{32'h0000_1000, 4'd3,  30'h400,      5'd4,  6'd0, 10'd0};
    tv[1] = '{32'h0000_2007, 4'd0,  30'h801,      5'd1,  6'd1, 10'd4};
    tv[2] = '{32'hFFFF_FFFC, 4'd15, 30'h3FFFFFFF, 5'd16, 6'd2, 10'd5};
    tv[3] = '{32'h0000_0ABF, 4'd7,  30'h2AF,      5'd8,  6'd3, 10'd21};
    do_reset();
    idle(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      do_cmd(tv[i].addr, tv[i].len, 0);
      chk("tbl_alloc_tag", cap_tag, tv[i].tag);
      chk("tbl_alloc_bufa", cap_bufa, tv[i].bufa);
      chk("tbl_tlp_addr", cap_addr, tv[i].t_addr);
      chk("tbl_tlp_len", cap_len, tv[i].t_len);
      chk("tbl_tlp_tag", cap_ttag, tv[i].tag);
      chk("tbl_latency", cap_stall, 0);
    end
    idle(1, 0, 0);
    chk("after_tag", alloc_tag, 4);
    chk("after_bufa", alloc_bufa, 29);
    do_cmd(32'h3000, 4'd5, 4);
    chk("simul_latency", cap_stall, 0);
    drain();
    do_cmd(32'h4000, 4'd2, 3);
    chk("bp_stall", cap_stall, 4);
    drain();
    idle(5, 0, 1);
    idle(1, 0, 0);
    drive(0, 0, 0); axi_ar_valid = 1; axi_ar_addr = 32'h5000; axi_ar_len = 4'd1;
    @(posedge clk); #1;
    axi_ar_valid = 0; rst = 1; #1;
    chk("midrst_alloc_valid", alloc_valid, 0); chk("midrst_init", alloc_init, 1);
    chk("midrst_ready", axi_ar_ready, 0); chk("midrst_tlp_len", tlp_len, 0);
    do_reset();
    for (int i = 0; i < 32; i++) do_cmd(32'h10000 + 32'(i * 4), 4'd0, 0);
    do_cmd(32'h8000, 4'd0, 2);
    chk("tagwrap_alloc_tag", cap_tag, 6'h20);
    chk("tagwrap_tlp_tag", cap_ttag, 0);
    chk("tagwrap_stall", cap_stall, 4);
    drain();
    do_reset();
    for (int i = 0; i < 32; i++) do_cmd(32'h20000 + 32'(i * 64), 4'd15, 0);
    do_cmd(32'h9000, 4'd0, 2);
    chk("datawrap_bufa", cap_bufa, 10'h200);
    chk("datawrap_stall", cap_stall, 4);
    drain();
    do_reset();
    for (int i = 0; i < 150; i++) begin
      do_cmd($urandom, 4'($urandom), 1);
      if ($urandom_range(2, 0) == 0) idle($urandom_range(3, 1), 1, 0);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
